siso_branch_ingest: RTL

// - Parametrised front end of the SISO decoder. Replaces the fixed sys/parity split and branch-init pair.
// - Takes the serial LLR stream (STREAMS LLRs per trellis step), aligns it with buffered a-priori LLRs and frames each block of blklen data steps plus TAIL_LEN tail steps.
// - Emits per-step branch metrics to the alpha/beta units, with step-level framing flags and backpressure.

---
 rtl/siso_pkg.sv | 31 +++
 rtl/siso_apr_fifo.sv | 55 +++++
 rtl/siso_branch_ingest.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/siso_pkg.sv
// Shared types and saturating arithmetic for the SISO branch-metric front end.
package siso_pkg;

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  localparam int ERR_BAD_LEN  = 0;
  localparam int ERR_UNDERRUN = 1;
  localparam int ERR_OVERFLOW = 2;

  // Wide enough that a three-term sum of any legal LLR width cannot wrap.
  localparam int SAT_W = 64;

  // a + b +/- c, clamped to the signed range of out_w bits.
  function automatic logic signed [SAT_W-1:0] sat_add3(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input logic signed [SAT_W-1:0] c,
    input logic                    sub,
    input int                      out_w
  );
    logic signed [SAT_W-1:0] s, one, hi, lo;
    one = 1;
    s   = sub ? (a + b - c) : (a + b + c);
    hi  = (one <<< (out_w - 1)) - one;
    lo  = ~hi;
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    else             return s;
  endfunction

endpackage

// File: rtl/siso_apr_fifo.sv
// Synchronous a-priori FIFO; a push while full only lands if a pop frees a slot the same cycle.
module siso_apr_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_pop, do_push, wr_en;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & full & ~do_pop;
  // A push coinciding with a flush survives as the sole entry.
  assign wr_en    = flush ? push : do_push;
  assign dout     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      wr_ptr <= wr_ptr + AW'(push);
      count  <= CW'(push);
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/siso_branch_ingest.sv
// SISO front end: frames the serial LLR stream into trellis steps, joins a-priori LLRs
// and registers saturated branch-metric pairs with data/tail/last framing.
module siso_branch_ingest
  import siso_pkg::*;
#(
  parameter int LLR_W     = 16,
  parameter int STREAMS   = 2,
  parameter int PAR_SEL   = 1,
  parameter int LEN_W     = 16,
  parameter int MAX_BLK   = 6144,
  parameter int TAIL_LEN  = 3,
  parameter int APR_DEPTH = 8,
  parameter int OUT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] blklen,
  input  logic             valid_blklen,
  input  logic [LLR_W-1:0] in,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [LLR_W-1:0] apriori,
  input  logic             valid_apriori,
  output logic [OUT_W-1:0] init_branch1,
  output logic [OUT_W-1:0] init_branch2,
  output logic             valid_branch,
  output logic             tail_branch,
  output logic             last_branch,
  output logic             ready,
  output logic [2:0]       err
);

  localparam int BW = (STREAMS > 1) ? $clog2(STREAMS) : 1;
  localparam int CW = $clog2(APR_DEPTH) + 1;
  localparam logic [BW-1:0]    LAST_BEAT = BW'(STREAMS - 1);
  localparam logic [BW-1:0]    PAR_BEAT  = BW'(PAR_SEL);
  localparam logic [LEN_W-1:0] TAIL_LAST = LEN_W'((TAIL_LEN > 0) ? TAIL_LEN - 1 : 0);
  localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_BLK);

  state_t state, state_n;

  logic [BW-1:0]           beat;
  logic [LEN_W-1:0]        step, blk_last;
  logic signed [LLR_W-1:0] sys_q, par_q, par_cur, apr_cur;
  logic                    hold;
  logic [2:0]              err_n;

  logic          xfer, tuple_done, apr_avail, fire_data, fire_tail, fire;
  logic          data_end, tail_end, blk_ok, blk_bad, leftover, bypass;
  logic          fifo_push, fifo_pop, fifo_empty, fifo_full, fifo_ovf;
  logic [LLR_W-1:0] fifo_dout;
  logic [CW-1:0]    fifo_count;

  logic signed [SAT_W-1:0] sys_x, par_x, apr_x, sum1, sum2;

  siso_apr_fifo #(.DEPTH(APR_DEPTH), .W(LLR_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .flush    (data_end),
    .din      (apriori),
    .dout     (fifo_dout),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .overflow (fifo_ovf),
    .count    (fifo_count)
  );

  assign ready      = (state == IDLE);
  assign ready_in   = (state != IDLE) & ~hold;
  assign xfer       = valid_in & ready_in;
  assign tuple_done = xfer & (beat == LAST_BEAT);
  assign par_cur    = (xfer && beat == PAR_BEAT) ? in : par_q;

  // An apriori arriving while the FIFO is empty is consumed directly.
  assign apr_avail  = ~fifo_empty | valid_apriori;
  assign fire_data  = (state == DATA) & (tuple_done | hold) & apr_avail;
  assign fire_tail  = (state == TAIL) & tuple_done;
  assign fire       = fire_data | fire_tail;
  assign fifo_pop   = fire_data & ~fifo_empty;
  assign bypass     = fire_data & fifo_empty;
  assign fifo_push  = valid_apriori & ~bypass;
  assign apr_cur    = (state == DATA) ? (fifo_empty ? apriori : fifo_dout) : '0;

  assign data_end   = fire_data & (step == blk_last);
  assign tail_end   = fire_tail & (step == TAIL_LAST);
  assign blk_ok     = valid_blklen & ready & (blklen != '0) & (blklen <= MAX_LEN);
  assign blk_bad    = valid_blklen & ready & ~((blklen != '0) & (blklen <= MAX_LEN));
  assign leftover   = data_end & (fifo_count > CW'(fifo_pop));

  assign sys_x = {{(SAT_W-LLR_W){sys_q[LLR_W-1]}},   sys_q};
  assign par_x = {{(SAT_W-LLR_W){par_cur[LLR_W-1]}}, par_cur};
  assign apr_x = {{(SAT_W-LLR_W){apr_cur[LLR_W-1]}}, apr_cur};
  assign sum1  = sat_add3(sys_x, apr_x, par_x, 1'b0, OUT_W);
  assign sum2  = sat_add3(sys_x, apr_x, par_x, 1'b1, OUT_W);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (blk_ok)   state_n = DATA;
      DATA:    if (data_end) state_n = (TAIL_LEN > 0) ? TAIL : IDLE;
      TAIL:    if (tail_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    err_n = blk_ok ? 3'b000 : err;
    if (blk_bad)  err_n[ERR_BAD_LEN]  = 1'b1;
    if (leftover) err_n[ERR_UNDERRUN] = 1'b1;
    if (fifo_ovf) err_n[ERR_OVERFLOW] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      beat         <= '0;
      step         <= '0;
      blk_last     <= '0;
      sys_q        <= '0;
      par_q        <= '0;
      hold         <= 1'b0;
      init_branch1 <= '0;
      init_branch2 <= '0;
      valid_branch <= 1'b0;
      tail_branch  <= 1'b0;
      last_branch  <= 1'b0;
      err          <= '0;
    end else begin
      state        <= state_n;
      err          <= err_n;
      valid_branch <= fire;
      tail_branch  <= fire & (state == TAIL);
      last_branch  <= tail_end | (data_end & (TAIL_LEN == 0));
      if (fire) begin
        init_branch1 <= sum1[OUT_W-1:0];
        init_branch2 <= sum2[OUT_W-1:0];
      end
      if (xfer) begin
        if (beat == '0)      sys_q <= in;
        if (beat == PAR_BEAT) par_q <= in;
        beat <= tuple_done ? '0 : beat + BW'(1);
      end
      if (tuple_done && state == DATA && !apr_avail) hold <= 1'b1;
      else if (fire_data)                            hold <= 1'b0;
      if (blk_ok) begin
        step     <= '0;
        blk_last <= blklen - LEN_W'(1);
      end else if (data_end || tail_end) begin
        step <= '0;
      end else if (fire) begin
        step <= step + LEN_W'(1);
      end
    end
  end

endmodule
